// File: rtl/spike_rr_arbiter_n.sv
// -----------------------------------------------------------------------------
// spike_rr_arbiter_n
// N-input round-robin arbiter that merges valid/ready spike channels onto one
// registered output and tags every packet with its source channel index.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   [N_IN]        per-channel request
//   in_ready   [N_IN]        per-channel accept (one-hot or zero)
//   in_data    [N_IN*WIDTH]  packed payloads, channel i at [i*WIDTH +: WIDTH]
//   out_valid                output register holds a packet
//   out_ready                downstream accept
//   out_data   [WIDTH]       granted payload
//   out_idx    [IDX_W]       source channel of out_data
//   grant_cnt  [N_IN*16]     per-channel saturating grant counters
//                            (present only when SPIKE_ARB_GRANT_CNT_EN is defined)
//
// Optional feature macro: SPIKE_ARB_GRANT_CNT_EN
// -----------------------------------------------------------------------------
module spike_rr_arbiter_n #(
   parameter  int N_IN  = 4,
   parameter  int WIDTH = 32,
   localparam int IDX_W = $clog2(N_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_IN-1:0]         in_valid,
   output logic [N_IN-1:0]         in_ready,
   input  logic [N_IN*WIDTH-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [IDX_W-1:0]        out_idx
`ifdef SPIKE_ARB_GRANT_CNT_EN
   ,
   output logic [N_IN*16-1:0]      grant_cnt
`endif
);

   logic [IDX_W-1:0] ptr_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_data_r;
   logic [IDX_W-1:0] out_idx_r;

   logic             load_s;
   logic             found_s;
   logic             hi_found_s;
   logic [IDX_W-1:0] hi_idx_s;
   logic [IDX_W-1:0] lo_idx_s;
   logic [IDX_W-1:0] win_s;
   logic [WIDTH-1:0] win_data_s;
   logic [N_IN-1:0]  in_ready_s;
   logic             in_hs_s;
   logic [IDX_W-1:0] ptr_next_s;

   // The output register can take a new packet when empty or being drained.
   assign load_s = !out_valid_r || out_ready;

   // Round-robin winner: lowest valid channel at or above ptr, otherwise the
   // lowest valid channel overall (the wrap-around part of the search).
   always_comb begin
      logic hi_sel;
      hi_sel     = 1'b0;
      hi_found_s = 1'b0;
      hi_idx_s   = '0;
      lo_idx_s   = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         hi_sel     = in_valid[i] && (IDX_W'(i) >= ptr_r);
         hi_found_s = hi_found_s | hi_sel;
         hi_idx_s   = hi_sel ? IDX_W'(i) : hi_idx_s;
         lo_idx_s   = in_valid[i] ? IDX_W'(i) : lo_idx_s;
      end
      found_s = |in_valid;
      win_s   = hi_found_s ? hi_idx_s : lo_idx_s;
   end

   // Payload mux for the selected channel.
   always_comb begin
      win_data_s = '0;
      for (int i = 0; i < N_IN; i++) begin
         win_data_s = (IDX_W'(i) == win_s) ? in_data[i*WIDTH +: WIDTH] : win_data_s;
      end
   end

   // Accept strobe and next pointer; in_ready is held low during reset.
   always_comb begin
      if (found_s && load_s && !rst) begin
         in_ready_s = N_IN'(1) << win_s;
         in_hs_s    = 1'b1;
      end else begin
         in_ready_s = '0;
         in_hs_s    = 1'b0;
      end
      ptr_next_s = (win_s == IDX_W'(N_IN - 1)) ? '0 : win_s + IDX_W'(1);
   end

   // Output register and priority pointer; pointer moves only on an input handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_idx_r   <= '0;
         ptr_r       <= '0;
      end else if (in_hs_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= win_data_s;
         out_idx_r   <= win_s;
         ptr_r       <= ptr_next_s;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_idx   = out_idx_r;

`ifdef SPIKE_ARB_GRANT_CNT_EN
   logic [N_IN-1:0][15:0] grant_cnt_r;

   // Per-channel saturating grant counters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_IN; i++) begin
         if (rst) begin
            grant_cnt_r[i] <= 16'h0000;
         end else if (in_ready_s[i] && in_valid[i] && (grant_cnt_r[i] != 16'hFFFF)) begin
            grant_cnt_r[i] <= grant_cnt_r[i] + 16'h0001;
         end
      end
   end

   assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_spike_rr_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_spike_rr_arbiter_n
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a behavioural round-robin model (modulo search over a
// pending-request array, plain integers for pointer/output/counters).
// -----------------------------------------------------------------------------
module tb_spike_rr_arbiter_n;

   localparam int N     = 4;
   localparam int W     = 32;
   localparam int IDX_W = $clog2(N);

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      in_valid;
   logic [N-1:0]      in_ready;
   logic [N*W-1:0]    in_data;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic [IDX_W-1:0]  out_idx;
`ifdef SPIKE_ARB_GRANT_CNT_EN
   logic [N*16-1:0]   grant_cnt;
`endif

   spike_rr_arbiter_n #(.N_IN(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx)
`ifdef SPIKE_ARB_GRANT_CNT_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Sender side: each channel holds one pending packet until accepted.
   bit          pend[N];
   logic [W-1:0] pdata[N];
   int          seq = 0;

   // Reference model state.
   bit          m_valid;
   logic [W-1:0] m_data;
   int          m_idx;
   int          m_ptr;
   int          m_cnt[N];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_winner(input int p);
      for (int k = 0; k < N; k++) begin
         if (pend[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic post(input int ch, input logic [W-1:0] d);
      pend[ch]  = 1'b1;
      pdata[ch] = d;
   endtask

   task automatic refill(input int pct, input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && mask[i] && ($urandom_range(99) < pct)) begin
            post(i, (W'(i) << 28) | W'(seq));
            seq++;
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         in_valid[i]         = pend[i];
         in_data[i*W +: W]   = pdata[i];
      end
   endtask

   // One clock: drive, check combinational accept, advance model, check outputs.
   task automatic cycle();
      int w;
      logic [N-1:0] er;
      drive();
      #1;
      w  = model_winner(m_ptr);
      er = '0;
      if (!rst && (!m_valid || out_ready) && (w >= 0)) er = N'(1) << w;
      check_eq("in_ready", 64'(in_ready), 64'(er));
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_idx = 0; m_ptr = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (er != '0) begin
         m_valid = 1'b1; m_data = pdata[w]; m_idx = w; m_ptr = (w + 1) % N;
         if (m_cnt[w] < 65535) m_cnt[w]++;
         pend[w] = 1'b0;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      check_eq("out_valid", 64'(out_valid), 64'(m_valid));
      check_eq("out_data",  64'(out_data),  64'(m_data));
      check_eq("out_idx",   64'(out_idx),   64'(m_idx));
`ifdef SPIKE_ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++)
         check_eq("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
   endtask

   task automatic clear_senders();
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pdata[i] = '0; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b1; in_valid = '0; in_data = '0;
      m_valid = 1'b0; m_data = '0; m_idx = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      clear_senders();

      // 1: reset with requests present (in_ready must stay low), then idle.
      for (int i = 0; i < N; i++) post(i, W'(32'h1000_0000 + i));
      cycle();
      clear_senders();
      cycle();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cycle();
         check_eq("idle_valid", 64'(out_valid), 64'd0);
         check_eq("idle_ready", 64'(in_ready), 64'd0);
      end

      // 2: single request on ch2.
      post(2, 32'hAAAA_0002);
      drive(); #1;
      check_eq("ch2_ready", 64'(in_ready), 64'b0100);
      cycle();
      check_eq("ch2_data", 64'(out_data), 64'hAAAA_0002);
      check_eq("ch2_idx",  64'(out_idx),  64'd2);

      // 3: all channels continuously valid -> 0,1,2,3,0,1 with no bubbles.
      do_reset();
      for (int c = 0; c < 6; c++) begin
         refill(100, 4'hF);
         cycle();
         check_eq("rr_valid", 64'(out_valid), 64'd1);
         check_eq("rr_idx",   64'(out_idx),   64'(c % 4));
      end

      // 4: ch1/ch3 with backpressure after first grant.
      clear_senders();
      do_reset();
      refill(100, 4'b1010);
      cycle();
      check_eq("bp_first_idx", 64'(out_idx), 64'd1);
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         refill(100, 4'b1010);
         cycle();
         check_eq("bp_hold_idx",   64'(out_idx),  64'd1);
         check_eq("bp_hold_data",  64'(out_data[27:0] <= 28'hFFFFFFF ? out_data[31:28] : 4'h0), 64'd1);
         check_eq("bp_hold_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      refill(100, 4'b1010);
      cycle();
      check_eq("bp_rel_idx0", 64'(out_idx), 64'd3);
      refill(100, 4'b1010);
      cycle();
      check_eq("bp_rel_idx1", 64'(out_idx), 64'd1);

      // 5: reset while holding a packet with ch0 pending.
      clear_senders();
      do_reset();
      post(1, 32'h1111_0001);
      cycle();
      out_ready = 1'b0;
      post(0, 32'h0000_00C0);
      cycle();
      check_eq("mid_valid_before", 64'(out_valid), 64'd1);
      rst = 1'b1;
      cycle();
      check_eq("mid_valid_after", 64'(out_valid), 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      cycle();
      check_eq("mid_regrant_idx",  64'(out_idx),  64'd0);
      check_eq("mid_regrant_data", 64'(out_data), 64'h0000_00C0);

      // 6: full rotation count check (grant counters when present).
      clear_senders();
      do_reset();
      for (int c = 0; c < 3 * N; c++) begin
         refill(100, 4'hF);
         cycle();
      end
      check_eq("rot_idx_wrap", 64'(out_idx), 64'(N - 1));

      // Randomized traffic with random backpressure, load and rare resets.
      for (int c = 0; c < 3000; c++) begin
         int pct;
         pct = 20 + 20 * ((c / 250) % 4);
         out_ready = ($urandom_range(3) != 0);
         rst = ($urandom_range(149) == 0);
         refill(pct, 4'hF);
         cycle();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
